rgb2hue_seq_ctrl: RTL and testbench

RGB2HUE_SEQ_CTRL -- requirements
Module: rgb2hue_seq_ctrl

---
 rtl/rgb2hue_seq_ctrl_pkg.sv | 37 +++
 rtl/rgb2hue_seq_ctrl_if.sv | 31 +++
 rtl/rgb2hue_seq_ctrl_div.sv | 67 ++++++
 rtl/rgb2hue_seq_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_rgb2hue_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb2hue_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb2hue_seq_ctrl_pkg
// Description : Shared types and constants for the sequential RGB-to-hue unit
// Revision    : 1.0 - initial release
// ============================================================================
package rgb2hue_seq_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_DIV   = 3'd2,
        ST_SCALE = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // Colour component holding the maximum (ties resolved r, then g, then b)
    typedef enum logic [1:0] {
        SEC_R = 2'd0,
        SEC_G = 2'd1,
        SEC_B = 2'd2
    } sector_t;

    localparam int unsigned c_DEG_60  = 60;
    localparam int unsigned c_DEG_360 = 360;
    localparam int unsigned c_OFF_R   = 0;
    localparam int unsigned c_OFF_G   = 2;
    localparam int unsigned c_OFF_B   = 4;

    // Magnitude of the difference of two 8-bit components
    function automatic logic [7:0] absdiff8(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb2hue_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rgb2hue_seq_ctrl_if
// Description : Pixel-in / hue-out valid-ready bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface rgb2hue_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       r;
    logic [7:0]       g;
    logic [7:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] hue;

    // Producer/consumer side
    modport master (
        output in_valid, r, g, b, out_ready,
        input  in_ready, out_valid, hue
    );

    // Hue unit side
    modport slave (
        input  in_valid, r, g, b, out_ready,
        output in_ready, out_valid, hue
    );
endinterface
`default_nettype wire

// File: rtl/rgb2hue_seq_ctrl_div.sv
`default_nettype none
// ============================================================================
// Module      : hue_serial_div
// Description : Restoring divider, one quotient bit per cycle, 8-bit divisor.
//               done_o is high during the cycle whose edge retires the last
//               bit; quot_o is complete from the following cycle on.
// Revision    : 1.0 - initial release
// ============================================================================
module hue_serial_div #(
    parameter int DIVW = 12
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            start_i,
    input  wire logic [DIVW-1:0] dividend_i,
    input  wire logic [7:0]      divisor_i,
    output logic                 done_o,
    output logic [DIVW-1:0]      quot_o
);
    localparam int CW = $clog2(DIVW + 1);

    logic          run_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    rem_q;
    logic [7:0]    dsr_q;
    logic [DIVW-1:0] acc_q;   // dividend bits shift out, quotient bits shift in

    logic [8:0] shifted_w;
    logic       ge_w;
    logic [7:0] sub_w;

    // One restoring step: bring down next dividend bit, trial-subtract divisor
    always_comb begin
        shifted_w = {rem_q, acc_q[DIVW-1]};
        ge_w      = (shifted_w >= {1'b0, dsr_q});
        sub_w     = shifted_w[7:0] - dsr_q;
    end

    // Divider state: load on start, then iterate DIVW times
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            acc_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= CW'(DIVW);
            rem_q <= '0;
            dsr_q <= divisor_i;
            acc_q <= dividend_i;
        end else if (run_q) begin
            rem_q <= ge_w ? sub_w : shifted_w[7:0];
            acc_q <= {acc_q[DIVW-2:0], ge_w};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o = run_q && (cnt_q == CW'(1));
    assign quot_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/rgb2hue_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rgb2hue_seq_ctrl
// Description : Sequential RGB-to-hue converter. A pixel is captured in IDLE,
//               PREP spends two cycles (min/max/sector, then dispatch), a
//               serial divider forms the fractional sector position and SCALE
//               multiplies by 60 degrees. Result held in OUT until taken.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb2hue_seq_ctrl
    import rgb2hue_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FIXED = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rgb2hue_seq_ctrl_if.slave  bus,
    output logic               busy_o
);
    localparam int DIVW = 8 + FIXED;

    state_t           state_q, state_d;
    logic             phase_q, phase_d;     // PREP: 0 = analyse, 1 = dispatch
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic [7:0]       diff_q, diff_d;
    logic [7:0]       num_q, num_d;
    sector_t          sec_q, sec_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hue_q, hue_d;

    logic             start_w;
    logic             done_w;
    logic [DIVW-1:0]  quot_w;
    logic [DIVW-1:0]  dividend_w;

    sector_t          prep_sec_w;
    logic [7:0]       prep_num_w, cmax_w, cmin_w;
    logic             prep_neg_w;
    logic [31:0]      q32_w, base_w, scale_w;

    // Sector analysis of the captured pixel
    always_comb begin
        prep_sec_w = SEC_R;
        prep_num_w = '0;
        prep_neg_w = 1'b0;
        cmax_w     = r_q;
        if (r_q >= g_q && r_q >= b_q) begin
            prep_sec_w = SEC_R;
            prep_num_w = absdiff8(g_q, b_q);
            prep_neg_w = (g_q < b_q);
            cmax_w     = r_q;
        end else if (g_q >= b_q) begin
            prep_sec_w = SEC_G;
            prep_num_w = absdiff8(b_q, r_q);
            prep_neg_w = (b_q < r_q);
            cmax_w     = g_q;
        end else begin
            prep_sec_w = SEC_B;
            prep_num_w = absdiff8(r_q, g_q);
            prep_neg_w = (r_q < g_q);
            cmax_w     = b_q;
        end
        if (r_q <= g_q) begin
            cmin_w = (r_q <= b_q) ? r_q : b_q;
        end else begin
            cmin_w = (g_q <= b_q) ? g_q : b_q;
        end
    end

    // Hue from sector offset and quotient; r-max with g<b wraps from 360
    always_comb begin
        q32_w   = 32'(quot_w);
        base_w  = 32'(c_OFF_R) << FIXED;
        scale_w = '0;
        case (sec_q)
            SEC_R: begin
                base_w  = 32'(c_OFF_R) << FIXED;
                scale_w = neg_q ? ((c_DEG_360 << FIXED) - q32_w * c_DEG_60)
                                : ((base_w + q32_w) * c_DEG_60);
            end
            SEC_G: begin
                base_w  = 32'(c_OFF_G) << FIXED;
                scale_w = (neg_q ? (base_w - q32_w) : (base_w + q32_w)) * c_DEG_60;
            end
            default: begin
                base_w  = 32'(c_OFF_B) << FIXED;
                scale_w = (neg_q ? (base_w - q32_w) : (base_w + q32_w)) * c_DEG_60;
            end
        endcase
    end

    assign dividend_w = DIVW'(num_q) << FIXED;

    // Next-state and datapath update for the controller
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        diff_d  = diff_q;
        num_d   = num_q;
        sec_d   = sec_q;
        neg_d   = neg_q;
        hue_d   = hue_q;
        start_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    r_d     = bus.r;
                    g_d     = bus.g;
                    b_d     = bus.b;
                    phase_d = 1'b0;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                if (!phase_q) begin
                    diff_d  = cmax_w - cmin_w;
                    num_d   = prep_num_w;
                    sec_d   = prep_sec_w;
                    neg_d   = prep_neg_w;
                    phase_d = 1'b1;
                end else if (diff_q == 8'd0) begin
                    hue_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    start_w = 1'b1;
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                if (done_w) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                hue_d   = WIDTH'(scale_w);
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            num_q   <= '0;
            sec_q   <= SEC_R;
            neg_q   <= 1'b0;
            hue_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            num_q   <= num_d;
            sec_q   <= sec_d;
            neg_q   <= neg_d;
            hue_q   <= hue_d;
        end
    end

    hue_serial_div #(
        .DIVW (DIVW)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_w),
        .dividend_i (dividend_w),
        .divisor_i  (diff_q),
        .done_o     (done_w),
        .quot_o     (quot_w)
    );

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.hue       = hue_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rgb2hue_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb2hue_seq_ctrl
// Description : Bench for rgb2hue_seq_ctrl: integer hue model + scoreboard,
//               literal vectors, stall, mid-division reset, random stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2hue_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int FIXED = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    always #5 clk = ~clk;

    rgb2hue_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rgb2hue_seq_ctrl #(
        .WIDTH (WIDTH),
        .FIXED (FIXED)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_out  = 0;
    bit rand_ordy = 1'b0;
    bit ordy_fix  = 1'b1;

    typedef struct {
        int hue;
        int lat;
        int t;
    } exp_t;
    exp_t sb[$];
    exp_t e_tmp;
    bit   seen_first = 1'b0;

    // Hue as plain integer arithmetic: sector offset plus truncated fraction
    function automatic int ref_hue(input int r, input int g, input int b);
        int mx, mn, d, q, one, h;
        one = 1 << FIXED;
        mx = (r > g) ? r : g; mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g; mn = (mn < b) ? mn : b;
        d  = mx - mn;
        if (d == 0) return 0;
        if (r == mx) begin
            q = (((g > b) ? g - b : b - g) * one) / d;
            h = (g < b) ? (360 * one - q * 60) : (q * 60);
        end else if (g == mx) begin
            q = (((b > r) ? b - r : r - b) * one) / d;
            h = ((b >= r) ? (2 * one + q) : (2 * one - q)) * 60;
        end else begin
            q = (((r > g) ? r - g : g - r) * one) / d;
            h = ((r >= g) ? (4 * one + q) : (4 * one - q)) * 60;
        end
        return h & ((1 << WIDTH) - 1);
    endfunction

    function automatic int ref_lat(input int r, input int g, input int b);
        return (r == g && g == b) ? 2 : 3 + 8 + FIXED;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_ordy ? 1'($urandom_range(0, 1)) : ordy_fix;
    end

    // Scoreboard: every cycle, compare outputs with the model's pending results
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            seen_first = 1'b0;
        end else begin
            chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~bus.in_ready});
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_out: out_valid=1 hue=%0d with nothing pending", bus.hue);
                end else begin
                    chk("sb_hue", {16'd0, bus.hue}, sb[0].hue);
                    if (!seen_first) begin
                        seen_first = 1'b1;
                        chk("sb_latency", cyc - sb[0].t, sb[0].lat);
                    end
                    if (bus.out_ready === 1'b1) begin
                        void'(sb.pop_front());
                        seen_first = 1'b0;
                        n_out++;
                    end
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                e_tmp.hue = ref_hue(int'(bus.r), int'(bus.g), int'(bus.b));
                e_tmp.lat = ref_lat(int'(bus.r), int'(bus.g), int'(bus.b));
                e_tmp.t   = cyc + 1;
                sb.push_back(e_tmp);
            end
        end
    end

    // Called at #1 after a transfer edge; waits for the result
    task automatic wait_out(input string name, input int exp_hue, input int exp_lat);
        int n;
        n = -1;
        for (int i = 0; i <= 60; i++) begin
            if (bus.out_valid === 1'b1) begin
                n = i;
                break;
            end
            @(posedge clk); #1;
        end
        chk({name, "_lat"}, n, exp_lat);
        chk({name, "_hue"}, {16'd0, bus.hue}, exp_hue);
    endtask

    task automatic run_px(input string name, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input int exp_hue, input int exp_lat);
        bit ok;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.r = r; bus.g = g; bus.b = b;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
        end
        chk({name, "_accept"}, {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(name, exp_hue, exp_lat);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit ok;
        int sel, v, mx;
        logic [7:0] pr, pg, pb;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.r = '0; bus.g = '0; bus.b = '0;
        #12;
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},          32'd0);
        chk("rst_hue",       {16'd0, bus.hue},       32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Hand-computed values pinning the model
        chk("model_b_max", ref_hue(0, 128, 255), 3360);
        chk("model_g_neg", ref_hue(128, 255, 0), 1440);
        chk("model_wrap",  ref_hue(255, 0, 128), 5280);

        run_px("red",     8'd255, 8'd0,   8'd0,   0,    15);
        run_px("green",   8'd0,   8'd255, 8'd0,   1920, 15);
        run_px("blue",    8'd0,   8'd0,   8'd255, 3840, 15);
        run_px("tie_rg",  8'd255, 8'd255, 8'd0,   960,  15);
        run_px("wrap",    8'd255, 8'd0,   8'd128, 5280, 15);
        run_px("gray",    8'd100, 8'd100, 8'd100, 0,    2);
        run_px("r_pos",   8'd255, 8'd128, 8'd0,   480,  15);
        run_px("g_neg",   8'd128, 8'd255, 8'd0,   1440, 15);
        run_px("b_neg",   8'd0,   8'd128, 8'd255, 3360, 15);

        // Consumer stall: result must hold, no new pixel accepted
        ordy_fix = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.r = 8'd0; bus.g = 8'd255; bus.b = 8'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out("stall", 1920, 15);
        bus.in_valid = 1'b1; bus.r = 8'd1; bus.g = 8'd2; bus.b = 8'd3;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_hue",   {16'd0, bus.hue},       32'd1920);
            chk("stall_ready", {31'd0, bus.in_ready},  32'd0);
        end
        bus.in_valid = 1'b0;
        ordy_fix = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("stall_release", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of the division
        n0 = n_out;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.r = 8'd255; bus.g = 8'd0; bus.b = 8'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("midrst_busy",      {31'd0, busy},          32'd0);
        chk("midrst_hue",       {16'd0, bus.hue},       32'd0);
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus.in_valid = 1'b1; bus.r = 8'd0; bus.g = 8'd0; bus.b = 8'd255;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("first_xfer_busy", {31'd0, busy}, 32'd1);
        wait_out("after_rst", 3840, 15);
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        chk("after_rst_count", n_out - n0, 1);

        // Back-to-back random stream with random consumer stalls
        n0 = n_out;
        rand_ordy = 1'b1;
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 3));
            v   = int'($urandom_range(0, 255));
            mx  = int'($urandom_range(0, 255));
            pr = 8'($urandom_range(0, 255));
            pg = 8'($urandom_range(0, 255));
            pb = 8'($urandom_range(0, 255));
            if (sel == 0) begin
                pr = 8'(v); pg = 8'(v); pb = 8'(v);
            end else if (sel == 1) begin
                pr = 8'(mx); pg = 8'(mx);
            end else if (sel == 2) begin
                pg = 8'(mx); pb = 8'(mx);
            end
            bus.in_valid = 1'b1; bus.r = pr; bus.g = pg; bus.b = pb;
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                chk("stream_accept", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rand_ordy = 1'b0;
        ordy_fix  = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("stream_count",   n_out - n0, 400);
        chk("stream_drained", sb.size(),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
